timer_pwm: RTL
==============

Name: timer_pwm

Overview:
- Tick-driven timer and PWM generator. Sits directly downstream of the prescaler and consumes its timing pulse as a count enable.
- Provides a period counter, compare-based PWM output and a sticky overflow flag for the core's interrupt logic.
- Period and compare values are shadowed so that PWM edges never glitch mid-period.

Parameters:
- WIDTH, 16, bit width of counter, period and compare values.

Ports:
- i_Clk  input  1  system clock.
- i_Rst  input  1  asynchronous reset, active-low.
- i_Tick  input  1  count enable from the prescaler's o_Timming. Each cycle sampled high advances the counter once.
- i_En  input  1  timer enable. Rising level starts a run; low stops and clears.
- i_Modo  input  1  0 = continuous, 1 = one-shot.
- i_Periodo  input  WIDTH  terminal count; period is i_Periodo+1 ticks.
- i_Comparacion  input  WIDTH  PWM compare value.
- i_Clr_Flag  input  1  clears o_Flag_Desborde.
- o_Cuenta  output  WIDTH  current count.
- o_Pwm  output  1  registered PWM output.
- o_Flag_Desborde  output  1  sticky wrap/overflow flag.
- o_Activo  output  1  high while in RUN.

Behaviour:
- Reset (i_Rst=0, async): state IDLE; o_Cuenta=0, o_Pwm=0, o_Flag_Desborde=0, o_Activo=0; shadow period and compare =0.
- FSM states: IDLE, RUN, DONE. All outputs are registered; each takes its new value on the clock edge after the condition is sampled.
- IDLE:
  - o_Cuenta=0, o_Pwm=0.
  - If i_En=1: latch i_Periodo and i_Comparacion into the shadows, go to RUN, drive o_Activo=1.
  - o_Pwm on the entry edge = (0 < shadow compare). Ticks in the entry cycle are ignored.
- RUN, edge with i_Tick=1:
  - If o_Cuenta != shadow period: o_Cuenta+1.
  - Else (wrap): o_Cuenta=0, set flag, re-latch both shadows from the inputs.
    - Continuous mode: stay in RUN.
    - One-shot mode: go to DONE.
- RUN, edge with i_Tick=0: hold all values.
- PWM rule: o_Pwm = (next o_Cuenta < compare shadow in effect for that count), unsigned compare. On the wrap edge, use the newly latched compare value.
  - compare=0: o_Pwm stays 0.
  - compare > period: o_Pwm stays 1.
- DONE: o_Cuenta=0, o_Pwm=0, o_Activo=0. Stay in DONE until i_En=0, then go to IDLE.
- i_En=0 in any state: go to IDLE on the next edge (counter and PWM clear there). The flag is retained.
- Period 0: every tick wraps and sets the flag; o_Pwm=1 only if compare >= 1.
- Mode sampling: i_Modo is sampled at each wrap, not latched at start.
- Flag: set on a wrap, cleared by i_Clr_Flag. If set and clear occur on the same edge, set wins.
- Counter arithmetic: WIDTH bits, never exceeds the shadow period, so there is no natural overflow.
- Reset asserted mid-run: immediate return to reset values regardless of clock.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
  - Mode constants (MODO_CONT=1'b0, MODO_UNICO=1'b1).
  - Default WIDTH.
- One sub-module is natural: timer_pwm_cmp, the registered compare/PWM output stage. The counter and FSM stay in the top module.

Test Plan:
- Reset mid-run: reset released, i_En=1, period=9, compare=3, continuous, i_Tick every cycle. o_Cuenta counts 0..9 and wraps. o_Pwm is high for counts 0-2 (3 of every 10 ticks). Flag sets at the first wrap. Pulsing i_Rst low at count 5 clears all outputs asynchronously.
- Prescaler-driven tick: i_Tick driven by a prescaler with frec=8, period=3, compare=2. The counter advances only on tick cycles. PWM is high 2 of every 4 ticks.
- One-shot: i_Modo=1, period=4. After 5 ticks the FSM reaches DONE: o_Activo=0, o_Cuenta=0, flag=1. Further ticks have no effect until i_En drops and rises again.
- Shadow update: in continuous mode with period=7, compare=2, change compare to 6 at count 3. PWM width stays 2 for the current period and becomes 6 from the next period.
- Boundaries:
  - compare=0: o_Pwm is always 0.
  - compare=20 with period=9: o_Pwm is always 1.
  - period=0, compare=1: flag sets every tick and o_Pwm=1.
- Flag race: assert i_Clr_Flag on the same edge as a wrap. The flag remains 1. Clearing on the next cycle with no wrap gives 0.

Source files
------------

// File: rtl/timer_pwm_pkg.sv
// -----------------------------------------------------------------------------
// timer_pwm_pkg
// Shared definitions for the tick-driven timer / PWM generator.
//   - DEF_WIDTH : default width of counter, period and compare values
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - MODO_*    : run-mode encodings sampled on i_Modo at every wrap
//   - cnt_step  : counter increment helper
// -----------------------------------------------------------------------------
package timer_pwm_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODO_CONT  = 1'b0;
    localparam logic MODO_UNICO = 1'b1;

    // Increment a DEF_WIDTH-bit count by one (wraps only in theory; the
    // timer never lets the count pass the shadow period).
    function automatic logic [DEF_WIDTH-1:0] cnt_step(input logic [DEF_WIDTH-1:0] cnt);
        cnt_step = cnt + {{(DEF_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/timer_pwm_cmp.sv
// -----------------------------------------------------------------------------
// timer_pwm_cmp
// Registered compare / PWM output stage. The PWM level is always computed
// from the count the timer is about to show, so o_Pwm lines up with o_Cuenta
// on the same clock edge.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous reset, active-low
//   pwm_clr  : force PWM low on the next edge (has priority)
//   pwm_upd  : load (cnt_nxt < cmp_val) on the next edge
//   cnt_nxt  : count value that becomes visible on the next edge
//   cmp_val  : compare value in effect for that count
//   pwm      : registered PWM output
// -----------------------------------------------------------------------------
module timer_pwm_cmp
    import timer_pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_clr,
    input  logic             pwm_upd,
    input  logic [WIDTH-1:0] cnt_nxt,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             pwm
);

    logic pwm_r;
    logic level_s;

    // Unsigned compare of the upcoming count against its compare value.
    always_comb begin
        level_s = 1'b0;
        if (cnt_nxt < cmp_val) begin
            level_s = 1'b1;
        end else begin
            level_s = 1'b0;
        end
    end

    // PWM output register: clear wins over update, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else if (pwm_clr) begin
            pwm_r <= 1'b0;
        end else if (pwm_upd) begin
            pwm_r <= level_s;
        end else begin
            pwm_r <= pwm_r;
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/timer_pwm.sv
// -----------------------------------------------------------------------------
// timer_pwm
// Tick-driven period counter with shadowed period/compare registers, a
// registered PWM output and a sticky overflow flag.
// Ports:
//   i_Clk           : system clock
//   i_Rst           : asynchronous reset, active-low
//   i_Tick          : count enable from the prescaler
//   i_En            : timer enable (high starts a run, low stops and clears)
//   i_Modo          : 0 = continuous, 1 = one-shot (sampled at every wrap)
//   i_Periodo       : terminal count, period is i_Periodo+1 ticks
//   i_Comparacion   : PWM compare value
//   i_Clr_Flag      : clears o_Flag_Desborde (a same-edge wrap wins)
//   o_Cuenta        : current count
//   o_Pwm           : registered PWM output
//   o_Flag_Desborde : sticky wrap flag
//   o_Activo        : high while running
// -----------------------------------------------------------------------------
module timer_pwm
    import timer_pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Tick,
    input  logic             i_En,
    input  logic             i_Modo,
    input  logic [WIDTH-1:0] i_Periodo,
    input  logic [WIDTH-1:0] i_Comparacion,
    input  logic             i_Clr_Flag,
    output logic [WIDTH-1:0] o_Cuenta,
    output logic             o_Pwm,
    output logic             o_Flag_Desborde,
    output logic             o_Activo
);

    state_t           state_r;
    logic [WIDTH-1:0] cuenta_r;
    logic [WIDTH-1:0] per_sh_r;
    logic [WIDTH-1:0] cmp_sh_r;
    logic             flag_r;
    logic             activo_r;

    logic             start_s;
    logic             step_s;
    logic             wrap_s;
    logic             at_term_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             pwm_clr_s;
    logic             pwm_upd_s;
    logic [WIDTH-1:0] pwm_cnt_s;
    logic [WIDTH-1:0] pwm_cmp_s;

    // Decode this cycle's event: start of a run, a plain count step or a wrap.
    always_comb begin
        start_s   = 1'b0;
        step_s    = 1'b0;
        wrap_s    = 1'b0;
        at_term_s = (cuenta_r == per_sh_r);
        cnt_inc_s = cuenta_r + {{(WIDTH-1){1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE: begin
                start_s = i_En;
            end
            ST_RUN: begin
                if (i_En && i_Tick) begin
                    wrap_s = at_term_s;
                    step_s = !at_term_s;
                end else begin
                    wrap_s = 1'b0;
                    step_s = 1'b0;
                end
            end
            ST_DONE: begin
                start_s = 1'b0;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // PWM stage control. On a step the current compare shadow applies; on
    // start and wrap the freshly latched compare (the input) applies to count 0.
    always_comb begin
        pwm_clr_s = 1'b0;
        pwm_upd_s = 1'b0;
        pwm_cnt_s = {WIDTH{1'b0}};
        pwm_cmp_s = i_Comparacion;
        if (!i_En) begin
            pwm_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pwm_upd_s = start_s;
                end
                ST_RUN: begin
                    if (step_s) begin
                        pwm_upd_s = 1'b1;
                        pwm_cnt_s = cnt_inc_s;
                        pwm_cmp_s = cmp_sh_r;
                    end else if (wrap_s) begin
                        // A one-shot wrap lands in DONE, where the PWM is low.
                        pwm_clr_s = (i_Modo == MODO_UNICO);
                        pwm_upd_s = (i_Modo == MODO_CONT);
                    end else begin
                        pwm_upd_s = 1'b0;
                    end
                end
                ST_DONE: begin
                    pwm_clr_s = 1'b1;
                end
                default: begin
                    pwm_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Timer FSM, counter, shadow registers, activity and sticky flag.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_r  <= ST_IDLE;
            cuenta_r <= {WIDTH{1'b0}};
            per_sh_r <= {WIDTH{1'b0}};
            cmp_sh_r <= {WIDTH{1'b0}};
            flag_r   <= 1'b0;
            activo_r <= 1'b0;
        end else begin
            if (!i_En) begin
                state_r  <= ST_IDLE;
                cuenta_r <= {WIDTH{1'b0}};
                activo_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r  <= ST_RUN;
                        per_sh_r <= i_Periodo;
                        cmp_sh_r <= i_Comparacion;
                        cuenta_r <= {WIDTH{1'b0}};
                        activo_r <= 1'b1;
                    end
                    ST_RUN: begin
                        if (wrap_s) begin
                            cuenta_r <= {WIDTH{1'b0}};
                            per_sh_r <= i_Periodo;
                            cmp_sh_r <= i_Comparacion;
                            if (i_Modo == MODO_UNICO) begin
                                state_r  <= ST_DONE;
                                activo_r <= 1'b0;
                            end else begin
                                state_r  <= ST_RUN;
                                activo_r <= 1'b1;
                            end
                        end else if (step_s) begin
                            cuenta_r <= cnt_inc_s;
                        end else begin
                            cuenta_r <= cuenta_r;
                        end
                    end
                    ST_DONE: begin
                        cuenta_r <= {WIDTH{1'b0}};
                        activo_r <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        cuenta_r <= {WIDTH{1'b0}};
                        activo_r <= 1'b0;
                    end
                endcase
            end
            // Set has priority over clear; wrap_s is already low when disabled.
            flag_r <= wrap_s | (flag_r & ~i_Clr_Flag);
        end
    end

    timer_pwm_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .clk     (i_Clk),
        .rst_n   (i_Rst),
        .pwm_clr (pwm_clr_s),
        .pwm_upd (pwm_upd_s),
        .cnt_nxt (pwm_cnt_s),
        .cmp_val (pwm_cmp_s),
        .pwm     (o_Pwm)
    );

    assign o_Cuenta        = cuenta_r;
    assign o_Flag_Desborde = flag_r;
    assign o_Activo        = activo_r;

endmodule
